state_probe_bank: RTL and testbench

STATE_PROBE_BANK -- requirements
Module: state_probe_bank

---
 rtl/state_probe_bank_if.sv | 23 ++
 rtl/state_probe_bank.sv | 143 ++++++++++++++
 tb/tb_state_probe_bank.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_probe_bank_if.sv
// rtl/state_probe_bank_if.sv - readout word stream handshake bundle
interface state_probe_bank_if #(
  parameter int OUT_WIDTH = 16
);
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/state_probe_bank.sv
// rtl/state_probe_bank.sv - live neuron state bits with snapshot readout as a word stream
module state_probe_bank #(
  parameter int NUM_NEURON      = 256,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int OUT_WIDTH       = 16,
  parameter int UPDATE_MODE     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [NEURON_ID_WIDTH:0]   cfg_active,
  input  logic                       spike_valid,
  input  logic [NEURON_ID_WIDTH-1:0] spike_id,
  input  logic [TEN_DATA_WIDTH-1:0]  spike_val,
  input  logic                       rd_req,
  state_probe_bank_if.master         out_if,
  output logic                       rd_done,
  output logic                       busy,
  output logic [15:0]                flip_count
);

  localparam int AW    = NEURON_ID_WIDTH + 1;
  localparam int NWMAX = (NUM_NEURON + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int PW    = NWMAX * OUT_WIDTH;
  localparam logic [AW-1:0] MAX_ACT = AW'(NUM_NEURON);

  typedef enum logic [1:0] {IDLE, SNAP, STREAM, DONE} state_t;

  state_t                st, st_nxt;
  logic [NUM_NEURON-1:0] live, shadow;
  logic [AW-1:0]         active, nwords, widx, widx_inc, nwords_calc;
  logic                  cfg_apply, spike_acc, spike_chg, new_bit, xfer;

  // Bits past the active count read as zero, including the padding of the last word.
  function automatic logic [OUT_WIDTH-1:0] word_of(input logic [NUM_NEURON-1:0] src,
                                                   input logic [AW-1:0] w,
                                                   input logic [AW-1:0] act);
    logic [PW-1:0]        padded;
    logic [OUT_WIDTH-1:0] r;
    padded = PW'(src) >> (32'(w) * 32'(OUT_WIDTH));
    for (int b = 0; b < OUT_WIDTH; b++) begin
      r[b] = padded[b] && ((32'(w) * 32'(OUT_WIDTH) + 32'(b)) < 32'(act));
    end
    return r;
  endfunction

  assign cfg_apply   = cfg_we && (st == IDLE);
  assign spike_acc   = spike_valid && ({1'b0, spike_id} < active) && !cfg_apply;
  assign xfer        = out_if.out_valid && out_if.out_ready;
  assign widx_inc    = widx + 1'b1;
  assign nwords_calc = AW'((32'(active) + 32'(OUT_WIDTH) - 32'd1) / 32'(OUT_WIDTH));

  always_comb begin
    new_bit   = 1'b0;
    spike_chg = 1'b0;
    if (UPDATE_MODE == 0) begin
      new_bit   = ~live[spike_id];
      spike_chg = spike_acc && (spike_val != '0);
    end else begin
      new_bit   = spike_val[0];
      spike_chg = spike_acc && (live[spike_id] != spike_val[0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt  = st;
    busy    = (st != IDLE);
    rd_done = (st == DONE);
    case (st)
      IDLE:    if (rd_req) st_nxt = SNAP;
      SNAP:    st_nxt = (nwords_calc == '0) ? DONE : STREAM;
      STREAM:  if (xfer && out_if.out_last) st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // The snapshot cycle restarts the flip count, but its own spike still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live       <= '1;
      active     <= MAX_ACT;
      flip_count <= 16'd0;
    end else if (cfg_apply) begin
      live       <= '1;
      active     <= (cfg_active > MAX_ACT) ? MAX_ACT : cfg_active;
      flip_count <= 16'd0;
    end else begin
      if (spike_chg) live[spike_id] <= new_bit;
      if (st == SNAP)
        flip_count <= {15'd0, spike_chg};
      else if (spike_chg && (flip_count != 16'hFFFF))
        flip_count <= flip_count + 16'd1;
    end
  end

  // Word 0 is built from the live array in SNAP so it is valid the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow           <= '1;
      nwords           <= '0;
      widx             <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
      out_if.out_data  <= '0;
    end else begin
      case (st)
        SNAP: begin
          shadow <= live;
          nwords <= nwords_calc;
          widx   <= '0;
          if (nwords_calc != '0) begin
            out_if.out_valid <= 1'b1;
            out_if.out_data  <= word_of(live, '0, active);
            out_if.out_last  <= (nwords_calc == AW'(1));
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_if.out_last) begin
              out_if.out_valid <= 1'b0;
              out_if.out_last  <= 1'b0;
              out_if.out_data  <= '0;
              widx             <= '0;
            end else begin
              widx            <= widx_inc;
              out_if.out_data <= word_of(shadow, widx_inc, active);
              out_if.out_last <= (widx_inc == nwords - 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_state_probe_bank.sv
// tb/tb_state_probe_bank.sv - toggle and write mode probe banks against a bit-array model
module tb_state_probe_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [8:0] cfg_active = 9'd0;
  logic       spike_valid = 1'b0;
  logic [7:0] spike_id = 8'd0;
  logic [1:0] spike_val = 2'd0;
  logic       rd_req = 1'b0;
  logic       ready = 1'b1;

  logic        rd_done0, busy0, rd_done1, busy1;
  logic [15:0] fc0, fc1;

  state_probe_bank_if #(.OUT_WIDTH(16)) if0 ();
  state_probe_bank_if #(.OUT_WIDTH(16)) if1 ();
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  state_probe_bank #(.UPDATE_MODE(0)) u_toggle (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_active(cfg_active),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_val(spike_val),
    .rd_req(rd_req), .out_if(if0), .rd_done(rd_done0), .busy(busy0), .flip_count(fc0)
  );

  state_probe_bank #(.UPDATE_MODE(1)) u_write (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_active(cfg_active),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_val(spike_val),
    .rd_req(rd_req), .out_if(if1), .rd_done(rd_done1), .busy(busy1), .flip_count(fc1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit m0[256];
  bit m1[256];
  int act = 256;
  int mf0 = 0;
  int mf1 = 0;
  bit m_busy = 1'b0;

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m0[i] = 1'b1;
      m1[i] = 1'b1;
    end
    act = 256;
    mf0 = 0;
    mf1 = 0;
    m_busy = 1'b0;
  endtask

  function automatic logic [15:0] exp_word(input int w, input bit which);
    logic [15:0] r;
    r = 16'd0;
    for (int b = 0; b < 16; b++) begin
      if (w * 16 + b < act) r[b] = which ? m1[w * 16 + b] : m0[w * 16 + b];
    end
    return r;
  endfunction

  // Applies the currently driven strobes to the model, then clocks them into the DUTs.
  task automatic cycle();
    int id;
    id = int'(spike_id);
    if (!reset) begin
      if (cfg_we && !m_busy) begin
        act = (int'(cfg_active) > 256) ? 256 : int'(cfg_active);
        for (int i = 0; i < 256; i++) begin
          m0[i] = 1'b1;
          m1[i] = 1'b1;
        end
        mf0 = 0;
        mf1 = 0;
      end else if (spike_valid && id < act) begin
        if (spike_val != 2'd0) begin
          m0[id] = !m0[id];
          if (mf0 < 65535) mf0++;
        end
        if (m1[id] != spike_val[0]) begin
          m1[id] = spike_val[0];
          if (mf1 < 65535) mf1++;
        end
      end
    end
    @(posedge clk);
    #1;
    spike_valid = 1'b0;
    cfg_we = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic set_cfg(input int v);
    cfg_we = 1'b1;
    cfg_active = 9'(v);
    cycle();
  endtask

  task automatic spike(input int id, input int val);
    spike_valid = 1'b1;
    spike_id = 8'(id);
    spike_val = 2'(val);
    cycle();
  endtask

  task automatic check_zero(input string tag);
    ck({tag, "_valid"}, {if1.out_valid, if0.out_valid}, 0);
    ck({tag, "_last"}, {if1.out_last, if0.out_last}, 0);
    ck({tag, "_data"}, {if1.out_data, if0.out_data}, 0);
    ck({tag, "_busy"}, {busy1, busy0}, 0);
    ck({tag, "_done"}, {rd_done1, rd_done0}, 0);
    ck({tag, "_fc"}, {fc1, fc0}, 0);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 five-cycle stall on word 2
  task automatic readout(input int rmode, input bit snap_spike, input int sid, input int sval,
                         input bit noise);
    logic [15:0] e0[16];
    logic [15:0] e1[16];
    logic [15:0] pd0, pd1;
    int nw, got, budget, stalls;
    bit prev_stall;
    rd_req = 1'b1;
    cycle();
    ck("snap_busy", busy0, 1);
    ck("snap_valid", if0.out_valid, 0);
    m_busy = 1'b1;
    nw = (act + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      e0[w] = exp_word(w, 1'b0);
      e1[w] = exp_word(w, 1'b1);
    end
    mf0 = 0;
    mf1 = 0;
    if (snap_spike) begin
      spike_valid = 1'b1;
      spike_id = 8'(sid);
      spike_val = 2'(sval);
    end
    cycle();
    ck("fc0_post_snap", fc0, mf0);
    ck("fc1_post_snap", fc1, mf1);
    got = 0;
    budget = 0;
    stalls = 0;
    prev_stall = 1'b0;
    pd0 = 16'd0;
    pd1 = 16'd0;
    while (got < nw && budget < 500) begin
      ck("stream_valid", {if1.out_valid, if0.out_valid}, 2'b11);
      if (prev_stall) begin
        ck("hold_data0", if0.out_data, pd0);
        ck("hold_data1", if1.out_data, pd1);
      end
      if (rmode == 0) ready = 1'b1;
      else if (rmode == 1) ready = 1'($urandom_range(0, 1));
      else ready = !(got == 2 && stalls < 5);
      if (!ready && got == 2) stalls++;
      if (ready) begin
        ck("word_toggle", if0.out_data, e0[got]);
        ck("word_write", if1.out_data, e1[got]);
        ck("word_last", {if1.out_last, if0.out_last}, (got == nw - 1) ? 2'b11 : 2'b00);
        got++;
      end
      spike_valid = 1'($urandom_range(0, 1));
      spike_id = 8'($urandom_range(0, 255));
      spike_val = 2'($urandom_range(0, 3));
      if (noise) begin
        cfg_we = 1'($urandom_range(0, 1));
        cfg_active = 9'($urandom_range(0, 300));
      end
      prev_stall = !ready;
      pd0 = if0.out_data;
      pd1 = if1.out_data;
      cycle();
      budget++;
    end
    ck("stream_words", got, nw);
    ck("done_pulse", {rd_done1, rd_done0}, 2'b11);
    ck("done_valid", {if1.out_valid, if0.out_valid}, 0);
    cycle();
    m_busy = 1'b0;
    ready = 1'b1;
    ck("idle_busy", {busy1, busy0}, 0);
    ck("idle_done", {rd_done1, rd_done0}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cycle();
    cycle();
    check_zero("reset");
    reset = 1'b0;
    cycle();

    readout(0, 1'b0, 0, 0, 1'b0);

    set_cfg(20);
    spike(3, 1);
    spike(25, 1);
    ck("fc0_pre_snap", fc0, mf0);
    ck("fc1_pre_snap", fc1, mf1);
    readout(0, 1'b0, 0, 0, 1'b0);
    readout(0, 1'b1, 3, 1, 1'b0);
    readout(0, 1'b0, 0, 0, 1'b0);

    set_cfg(300);
    readout(2, 1'b0, 0, 0, 1'b0);

    set_cfg(0);
    readout(0, 1'b0, 0, 0, 1'b0);
    set_cfg(100);
    readout(1, 1'b0, 0, 0, 1'b1);
    readout(0, 1'b0, 0, 0, 1'b0);

    set_cfg(256);
    spike(5, 2);
    ck("fc0_val2", fc0, mf0);
    ck("fc1_val2", fc1, mf1);
    readout(0, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) set_cfg(int'($urandom_range(0, 300)));
      for (int k = 0; k < 40; k++) begin
        spike_valid = 1'($urandom_range(0, 1));
        spike_id = 8'($urandom_range(0, 255));
        spike_val = 2'($urandom_range(0, 3));
        cycle();
      end
      ck("fc0_burst", fc0, mf0);
      ck("fc1_burst", fc1, mf1);
      readout(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    set_cfg(256);
    spike(7, 1);
    rd_req = 1'b1;
    cycle();
    m_busy = 1'b1;
    cycle();
    ready = 1'b1;
    cycle();
    cycle();
    ready = 1'b0;
    cycle();
    ck("pre_abort_valid", if0.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("abort");
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      ck("post_abort_done", {rd_done1, rd_done0}, 0);
      ck("post_abort_busy", {busy1, busy0}, 0);
    end
    readout(0, 1'b0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
